// File: rtl/reg_status_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_status_file_pkg
//  Description : Shared defaults and types for the architectural register
//                file / rename-tag table. Holds the default widths used by
//                the top and the read-port sub-module, plus the enum that
//                names which source a lookup port is returning.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_status_file_pkg;

    // Default geometry. NUM_REGS must be 2**REG_ID_W.
    localparam int unsigned c_XLEN_DEFAULT          = 32;
    localparam int unsigned c_NUM_REGS_DEFAULT      = 32;
    localparam int unsigned c_REG_ID_W_DEFAULT      = 5;
    localparam int unsigned c_ROB_WIDTH_BIT_DEFAULT = 4;
    // Two source operands per instruction, two instructions per issue bundle.
    localparam int unsigned c_NUM_READ_DEFAULT      = 4;

    // Which source a lookup port is drawing its answer from, listed in
    // decreasing priority.
    typedef enum logic [1:0] {
        LK_ZERO   = 2'd0,   // x0: hardwired zero, always ready
        LK_BYPASS = 2'd1,   // producer is committing this very cycle
        LK_WAIT   = 2'd2,   // producer still in flight, return its tag
        LK_REG    = 2'd3    // architectural value is current
    } lookup_src_e;

endpackage : reg_status_file_pkg
`default_nettype wire

// File: rtl/reg_status_file_reg_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : reg_read_port
//  Description : Purely combinational operand lookup for one read port.
//                Given the indexed entry of the register file / tag table
//                and the commit bus of the current cycle, decides whether the
//                operand is ready and returns either its value or the ROB tag
//                of its producer.
//
//  Ports:
//    ask_reg_id    in   REG_ID_W       register being looked up
//    reg_val       in   XLEN           regs[ask_reg_id]
//    reg_busy      in   1              is_Qi[ask_reg_id]
//    reg_tag       in   ROB_WIDTH_BIT  Qi[ask_reg_id]
//    bypass_en     in   1              commit bus may be forwarded this cycle
//    write_reg_id  in   REG_ID_W       commit destination (0 = none)
//    write_ROB_id  in   ROB_WIDTH_BIT  committing tag
//    write_val     in   XLEN           committing value
//    ret_val       out  XLEN           operand value (0 when waiting)
//    is_val        out  1              operand ready
//    ret_ROB_id    out  ROB_WIDTH_BIT  producer tag (0 when ready)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_read_port
    import reg_status_file_pkg::*;
#(
    parameter int unsigned XLEN          = c_XLEN_DEFAULT,
    parameter int unsigned REG_ID_W      = c_REG_ID_W_DEFAULT,
    parameter int unsigned ROB_WIDTH_BIT = c_ROB_WIDTH_BIT_DEFAULT
) (
    input  logic [REG_ID_W-1:0]      ask_reg_id,
    input  logic [XLEN-1:0]          reg_val,
    input  logic                     reg_busy,
    input  logic [ROB_WIDTH_BIT-1:0] reg_tag,
    input  logic                     bypass_en,
    input  logic [REG_ID_W-1:0]      write_reg_id,
    input  logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
    input  logic [XLEN-1:0]          write_val,
    output logic [XLEN-1:0]          ret_val,
    output logic                     is_val,
    output logic [ROB_WIDTH_BIT-1:0] ret_ROB_id
);

    lookup_src_e w_src;
    logic        w_hit_commit;

    // The commit bus only resolves this operand if it carries the exact tag
    // we are waiting on; an older (stale) producer writing the same register
    // must not satisfy a reader that depends on a younger one. Because the
    // register is non-zero on this path, write_reg_id==ask_reg_id also
    // implies a real commit.
    assign w_hit_commit = bypass_en
                        && (write_reg_id == ask_reg_id)
                        && (write_ROB_id == reg_tag);

    always_comb begin
        w_src = LK_REG;
        if (ask_reg_id == '0) begin
            w_src = LK_ZERO;
        end else if (reg_busy && w_hit_commit) begin
            w_src = LK_BYPASS;
        end else if (reg_busy) begin
            w_src = LK_WAIT;
        end
    end

    always_comb begin
        ret_val    = '0;
        is_val     = 1'b1;
        ret_ROB_id = '0;
        case (w_src)
            LK_ZERO: begin
                ret_val = '0;
            end
            LK_BYPASS: begin
                ret_val = write_val;
            end
            LK_WAIT: begin
                is_val     = 1'b0;
                ret_ROB_id = reg_tag;
            end
            LK_REG: begin
                ret_val = reg_val;
            end
            default: begin
                ret_val = '0;
            end
        endcase
    end

endmodule : reg_read_port
`default_nettype wire

// File: rtl/reg_status_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_status_file
//  Description : Architectural register file merged with the per-register
//                rename-tag (Qi) table. Issue looks up operands on NUM_READ
//                ports and renames one destination per cycle; ROB commit
//                writes one architectural value per cycle and releases the
//                matching tag. A misprediction flush drops every tag while
//                still letting the flushing instruction commit. busy_cnt
//                tracks how many registers currently carry a tag.
//
//  Ports:
//    clk_in        in   1                        clock
//    rst_in        in   1                        synchronous active-high reset
//    rdy_in        in   1                        0 = hold all state
//    clear_flag    in   1                        misprediction flush
//    ask_reg_id    in   NUM_READ*REG_ID_W        lookup indices, port k at slice k
//    ret_val       out  NUM_READ*XLEN            operand values
//    is_val        out  NUM_READ                 operand ready flags
//    ret_ROB_id    out  NUM_READ*ROB_WIDTH_BIT   producer tags
//    new_reg_id    in   REG_ID_W                 issue destination (0 = none)
//    new_ROB_id    in   ROB_WIDTH_BIT            issuing tag
//    write_reg_id  in   REG_ID_W                 commit destination (0 = none)
//    write_ROB_id  in   ROB_WIDTH_BIT            committing tag
//    write_val     in   XLEN                     commit value
//    busy_cnt      out  REG_ID_W+1               registers with a pending tag
//
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_status_file
    import reg_status_file_pkg::*;
#(
    parameter int unsigned XLEN          = c_XLEN_DEFAULT,
    parameter int unsigned NUM_REGS      = c_NUM_REGS_DEFAULT,
    parameter int unsigned REG_ID_W      = c_REG_ID_W_DEFAULT,
    parameter int unsigned ROB_WIDTH_BIT = c_ROB_WIDTH_BIT_DEFAULT,
    parameter int unsigned NUM_READ      = c_NUM_READ_DEFAULT
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              rdy_in,
    input  logic                              clear_flag,
    input  logic [NUM_READ*REG_ID_W-1:0]      ask_reg_id,
    output logic [NUM_READ*XLEN-1:0]          ret_val,
    output logic [NUM_READ-1:0]               is_val,
    output logic [NUM_READ*ROB_WIDTH_BIT-1:0] ret_ROB_id,
    input  logic [REG_ID_W-1:0]               new_reg_id,
    input  logic [ROB_WIDTH_BIT-1:0]          new_ROB_id,
    input  logic [REG_ID_W-1:0]               write_reg_id,
    input  logic [ROB_WIDTH_BIT-1:0]          write_ROB_id,
    input  logic [XLEN-1:0]                   write_val,
    output logic [REG_ID_W:0]                 busy_cnt
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]          r_regs [NUM_REGS];
    logic [ROB_WIDTH_BIT-1:0] r_qi   [NUM_REGS];
    logic [NUM_REGS-1:0]      r_is_qi;
    logic [REG_ID_W:0]        r_busy_cnt;

    // ------------------------------------------------------------------
    // Per-cycle decode of the commit and issue buses
    // ------------------------------------------------------------------
    logic              w_commit;       // architectural write this cycle
    logic              w_release;      // commit tag matches the live tag
    logic              w_rename;       // issue renames a real register
    logic              w_same_reg;     // release and rename hit one register
    logic              w_busy_inc;
    logic              w_busy_dec;
    logic              w_bypass_en;
    logic [REG_ID_W:0] w_busy_next;

    assign w_commit    = (write_reg_id != '0);
    assign w_release   = w_commit
                       && r_is_qi[write_reg_id]
                       && (r_qi[write_reg_id] == write_ROB_id);
    assign w_rename    = (new_reg_id != '0);
    assign w_same_reg  = w_rename && (new_reg_id == write_reg_id);

    // A rename of an already-busy register just retags it; a release that is
    // immediately re-renamed leaves the register busy. Only transitions of
    // is_Qi move the counter, which keeps it equal to popcount(is_Qi).
    assign w_busy_inc  = w_rename && !r_is_qi[new_reg_id];
    assign w_busy_dec  = w_release && !w_same_reg;

    always_comb begin
        w_busy_next = r_busy_cnt
                    + {{REG_ID_W{1'b0}}, w_busy_inc}
                    - {{REG_ID_W{1'b0}}, w_busy_dec};
    end

    // During a stall the commit bus is not real, and during a flush the tag
    // being waited on is about to vanish anyway, so forwarding is only
    // allowed on an ordinary active cycle.
    assign w_bypass_en = rdy_in && !clear_flag;

    // ------------------------------------------------------------------
    // Register file: values. x0 is never written.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (rdy_in) begin
            // The flushing branch itself still retires, so the commit write
            // is independent of clear_flag.
            if (w_commit) begin
                r_regs[write_reg_id] <= write_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // Rename-tag table and busy counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_qi[i] <= '0;
            end
            r_is_qi    <= '0;
            r_busy_cnt <= '0;
        end else if (rdy_in) begin
            if (clear_flag) begin
                // Everything younger than the mispredicted branch is gone;
                // the issue slot on this cycle belongs to the wrong path.
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    r_qi[i] <= '0;
                end
                r_is_qi    <= '0;
                r_busy_cnt <= '0;
            end else begin
                if (w_release) begin
                    r_is_qi[write_reg_id] <= 1'b0;
                    r_qi[write_reg_id]    <= '0;
                end
                // Placed after the release so that a same-register rename
                // overrides it: the new producer is the one readers need.
                if (w_rename) begin
                    r_is_qi[new_reg_id] <= 1'b1;
                    r_qi[new_reg_id]    <= new_ROB_id;
                end
                r_busy_cnt <= w_busy_next;
            end
        end
    end

    assign busy_cnt = r_busy_cnt;

    // ------------------------------------------------------------------
    // Lookup ports. They see the state as of the start of the cycle, so a
    // rename issued this cycle is invisible to this cycle's lookups.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < int'(NUM_READ); k++) begin : g_read_port
        logic [REG_ID_W-1:0] w_idx;

        assign w_idx = ask_reg_id[k*REG_ID_W +: REG_ID_W];

        reg_read_port #(
            .XLEN          (XLEN),
            .REG_ID_W      (REG_ID_W),
            .ROB_WIDTH_BIT (ROB_WIDTH_BIT)
        ) u_read_port (
            .ask_reg_id   (w_idx),
            .reg_val      (r_regs[w_idx]),
            .reg_busy     (r_is_qi[w_idx]),
            .reg_tag      (r_qi[w_idx]),
            .bypass_en    (w_bypass_en),
            .write_reg_id (write_reg_id),
            .write_ROB_id (write_ROB_id),
            .write_val    (write_val),
            .ret_val      (ret_val[k*XLEN +: XLEN]),
            .is_val       (is_val[k]),
            .ret_ROB_id   (ret_ROB_id[k*ROB_WIDTH_BIT +: ROB_WIDTH_BIT])
        );
    end

endmodule : reg_status_file
`default_nettype wire

// File: tb/tb_reg_status_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_status_file
//  Description : Self-checking bench for reg_status_file. Keeps a plain
//                array model of values, busy flags and tags, compares every
//                lookup port and busy_cnt each cycle, and pins key points of
//                the directed sequence with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_status_file;

    localparam int XL = 32;
    localparam int NR = 32;
    localparam int RW = 5;
    localparam int TW = 4;
    localparam int NP = 4;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in;
    logic              clear_flag;
    logic [NP*RW-1:0]  ask_reg_id;
    logic [NP*XL-1:0]  ret_val;
    logic [NP-1:0]     is_val;
    logic [NP*TW-1:0]  ret_ROB_id;
    logic [RW-1:0]     new_reg_id;
    logic [TW-1:0]     new_ROB_id;
    logic [RW-1:0]     write_reg_id;
    logic [TW-1:0]     write_ROB_id;
    logic [XL-1:0]     write_val;
    logic [RW:0]       busy_cnt;

    reg_status_file #(
        .XLEN(XL), .NUM_REGS(NR), .REG_ID_W(RW), .ROB_WIDTH_BIT(TW), .NUM_READ(NP)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .clear_flag   (clear_flag),
        .ask_reg_id   (ask_reg_id),
        .ret_val      (ret_val),
        .is_val       (is_val),
        .ret_ROB_id   (ret_ROB_id),
        .new_reg_id   (new_reg_id),
        .new_ROB_id   (new_ROB_id),
        .write_reg_id (write_reg_id),
        .write_ROB_id (write_ROB_id),
        .write_val    (write_val),
        .busy_cnt     (busy_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural model
    logic [XL-1:0] m_val  [NR];
    logic          m_busy [NR];
    logic [TW-1:0] m_tag  [NR];
    bit            m_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int model_busy_count();
        int c = 0;
        for (int i = 0; i < NR; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    task automatic model_update();
        if (rst_in) begin
            for (int i = 0; i < NR; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
            m_valid = 1'b1;
        end else if (rdy_in && m_valid) begin
            if (write_reg_id != 0) m_val[write_reg_id] = write_val;
            if (clear_flag) begin
                for (int i = 0; i < NR; i++) begin
                    m_busy[i] = 1'b0; m_tag[i] = '0;
                end
            end else begin
                if (write_reg_id != 0 && m_busy[write_reg_id] && m_tag[write_reg_id] == write_ROB_id)
                    m_busy[write_reg_id] = 1'b0;
                if (new_reg_id != 0) begin
                    m_busy[new_reg_id] = 1'b1;
                    m_tag[new_reg_id]  = new_ROB_id;
                end
            end
        end
    endtask

    // Compares every port and the busy counter against the model.
    task automatic check_all();
        if (!m_valid) return;
        for (int k = 0; k < NP; k++) begin
            int            r;
            logic          ev;
            logic [XL-1:0] evl;
            logic [TW-1:0] et;
            r = int'(ask_reg_id[k*RW +: RW]);
            ev = 1'b1; evl = '0; et = '0;
            if (r == 0) begin
                ev = 1'b1;
            end else if (m_busy[r] && rdy_in && !clear_flag
                         && int'(write_reg_id) == r && m_tag[r] == write_ROB_id) begin
                evl = write_val;
            end else if (m_busy[r]) begin
                ev = 1'b0; et = m_tag[r];
            end else begin
                evl = m_val[r];
            end
            n_checks++;
            if (is_val[k] !== ev || ret_val[k*XL +: XL] !== evl || ret_ROB_id[k*TW +: TW] !== et) begin
                n_fail++;
                $display("FAIL lookup port%0d r%0d @%0t: got is_val=%0b val=%h tag=%0d, want is_val=%0b val=%h tag=%0d",
                         k, r, $time, is_val[k], ret_val[k*XL +: XL], ret_ROB_id[k*TW +: TW], ev, evl, et);
            end
        end
        n_checks++;
        if (int'(busy_cnt) != model_busy_count() || $isunknown(busy_cnt)) begin
            n_fail++;
            $display("FAIL busy_cnt @%0t: got %0d, want %0d", $time, busy_cnt, model_busy_count());
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk_in);
        check_all();
    endtask

    task automatic edge_step();
        @(posedge clk_in);
        model_update();
        #1;
    endtask

    task automatic cycle();
        settle();
        edge_step();
    endtask

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1; clear_flag = 1'b0;
        new_reg_id = '0; new_ROB_id = '0;
        write_reg_id = '0; write_ROB_id = '0; write_val = '0;
    endtask

    task automatic ask(input int a0, input int a1, input int a2, input int a3);
        ask_reg_id = {RW'(a3), RW'(a2), RW'(a1), RW'(a0)};
    endtask

    task automatic issue(input int r, input int t);
        new_reg_id = RW'(r); new_ROB_id = TW'(t);
    endtask

    task automatic commit(input int r, input int t, input logic [XL-1:0] v);
        write_reg_id = RW'(r); write_ROB_id = TW'(t); write_val = v;
    endtask

    initial begin
        idle();
        ask(0, 0, 0, 0);
        rst_in = 1'b1;
        cycle();

        // Reset state, x0 and an empty rename
        idle(); ask(0, 5, 0, 5); issue(0, 3);
        settle();
        chk("reset r0 is_val", 64'(is_val[0]), 64'd1);
        chk("reset r5 is_val", 64'(is_val[1]), 64'd1);
        chk("reset r5 val", 64'(ret_val[XL +: XL]), 64'd0);
        chk("reset busy_cnt", 64'(busy_cnt), 64'd0);
        edge_step();
        idle(); ask(0, 5, 0, 0);
        settle();
        chk("no-rename busy_cnt", 64'(busy_cnt), 64'd0);
        edge_step();

        // Rename r3 -> tag 7, then commit with bypass
        idle(); issue(3, 7); ask(3, 0, 0, 0);
        settle();
        chk("same-cycle rename invisible", 64'(is_val[0]), 64'd1);
        edge_step();
        idle(); ask(3, 3, 0, 0);
        settle();
        chk("r3 waiting", 64'(is_val[0]), 64'd0);
        chk("r3 tag", 64'(ret_ROB_id[0 +: TW]), 64'd7);
        chk("busy after r3", 64'(busy_cnt), 64'd1);
        edge_step();
        idle(); commit(3, 7, 32'hDEADBEEF); ask(3, 0, 3, 0);
        settle();
        chk("bypass is_val", 64'(is_val[0]), 64'd1);
        chk("bypass val", 64'(ret_val[0 +: XL]), 64'hDEADBEEF);
        edge_step();
        idle(); ask(3, 0, 0, 0);
        settle();
        chk("r3 committed", 64'(ret_val[0 +: XL]), 64'hDEADBEEF);
        chk("busy after commit", 64'(busy_cnt), 64'd0);
        edge_step();
        idle(); issue(3, 8); ask(3, 3, 3, 3);
        cycle();
        idle(); commit(3, 8, 32'h0000_0033); ask(3, 0, 0, 0);
        cycle();

        // Stale commit on r4
        idle(); issue(4, 2); cycle();
        idle(); issue(4, 9); ask(4, 0, 0, 0); cycle();
        idle(); commit(4, 2, 32'h11); ask(4, 4, 0, 0);
        settle();
        chk("stale no bypass", 64'(is_val[0]), 64'd0);
        edge_step();
        idle(); ask(4, 0, 0, 0);
        settle();
        chk("stale keeps tag", 64'(ret_ROB_id[0 +: TW]), 64'd9);
        chk("stale busy_cnt", 64'(busy_cnt), 64'd1);
        edge_step();

        // Same-cycle release and rename of r6
        idle(); issue(6, 1); cycle();
        idle(); commit(6, 1, 32'h66); issue(6, 5); ask(6, 4, 0, 0); cycle();
        idle(); ask(6, 0, 0, 0);
        settle();
        chk("r6 retag", 64'(ret_ROB_id[0 +: TW]), 64'd5);
        chk("r6 busy_cnt", 64'(busy_cnt), 64'd2);
        edge_step();

        // Release one register while renaming another
        idle(); issue(7, 1); cycle();
        idle(); commit(7, 1, 32'h77); issue(10, 2); ask(7, 10, 0, 0); cycle();
        idle(); commit(10, 2, 32'hA0); ask(10, 7, 6, 4); cycle();

        // Tag r1, r2, r8 then flush together with a commit of r2
        idle(); issue(1, 3); cycle();
        idle(); issue(2, 4); cycle();
        idle(); issue(8, 6); ask(1, 2, 8, 6); cycle();
        idle(); clear_flag = 1'b1; commit(2, 4, 32'h42); issue(9, 10); ask(2, 9, 1, 0);
        settle();
        chk("no bypass on flush", 64'(is_val[0]), 64'd0);
        edge_step();
        idle(); ask(2, 4, 9, 6);
        settle();
        chk("flush r2 val", 64'(ret_val[0 +: XL]), 64'h42);
        chk("flush r4 val", 64'(ret_val[XL +: XL]), 64'h11);
        chk("flush r9 not renamed", 64'(is_val[2]), 64'd1);
        chk("flush busy_cnt", 64'(busy_cnt), 64'd0);
        edge_step();

        // Stall: nothing moves
        idle(); rdy_in = 1'b0; issue(5, 3); commit(2, 0, 32'h99); ask(2, 5, 0, 0); cycle();
        idle(); ask(2, 5, 0, 0);
        settle();
        chk("stall r2 kept", 64'(ret_val[0 +: XL]), 64'h42);
        chk("stall r5 untagged", 64'(is_val[1]), 64'd1);
        chk("stall busy_cnt", 64'(busy_cnt), 64'd0);
        edge_step();
        idle(); issue(5, 12); cycle();
        idle(); rdy_in = 1'b0; commit(5, 12, 32'h55); ask(5, 0, 0, 0);
        settle();
        chk("stall no bypass", 64'(is_val[0]), 64'd0);
        edge_step();
        idle(); ask(5, 2, 0, 0);
        settle();
        chk("stall r5 tag kept", 64'(ret_ROB_id[0 +: TW]), 64'd12);
        edge_step();

        // Reset mid-operation
        idle(); rst_in = 1'b1; rdy_in = 1'b0; clear_flag = 1'b1; ask(5, 2, 0, 0); cycle();
        idle(); ask(5, 2, 3, 4);
        settle();
        chk("post-reset r5 ready", 64'(is_val[0]), 64'd1);
        chk("post-reset r2 val", 64'(ret_val[XL +: XL]), 64'd0);
        chk("post-reset busy_cnt", 64'(busy_cnt), 64'd0);
        edge_step();
        idle(); cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_status_file
`default_nettype wire
